msix_message_generator: RTL
===========================

# msix_message_generator

Consumes the Table Offset/BIR value and the MSI-X control bits and turns per-vector interrupt requests into memory-write message requests. For each request it computes the table entry address, fetches the 16-byte entry over a table read port, and checks the function mask and vector mask. Unmasked vectors are emitted as address/data messages to the TLP builder. Masked vectors are recorded in the Pending Bit Array (PBA) and re-sent once unmasked. It sits between the MSI-X capability registers and the posted-request TLP path.

## Interface
- NUM_VECTORS, 32: number of table entries / PBA bits (1..2048)
- VEC_W, 11: width of vector index
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- table_offset_bir  in  32  [31:3] QWORD table offset, [2:0] BIR
- tbl_bir  out  3  equals table_offset_bir[2:0]; upstream muxes the matching BAR into bar_base
- bar_base  in  64  base address of the BAR selected by tbl_bir
- msix_enable  in  1  MSI-X Enable
- function_mask  in  1  Function Mask
- vec_req_valid / vec_req_ready  in / out  1  interrupt request handshake
- vec_req_num  in  VEC_W  requested vector
- tbl_rd_req  out  1  table entry read request, held until ack
- tbl_rd_addr  out  64  entry address, bits [3:0] always 0
- tbl_rd_ack  in  1  read complete; tbl_rd_data valid this cycle
- tbl_rd_data  in  128  [31:0] addr lo, [63:32] addr hi, [95:64] data, [96] vector mask
- msg_valid / msg_ready  out / in  1  message handshake
- msg_addr  out  64  {addr hi, addr lo[31:2], 2'b00}
- msg_data  out  32  message data
- pba  out  NUM_VECTORS  pending bits
- err_pulse  out  1  one-cycle flag for out-of-range vector

## Operation
- Entry address = bar_base + {table_offset_bir[31:3], 3'b000} + vec*16, computed modulo 2^64.
- FSM states: IDLE, RD, EVAL, SEND.
- IDLE:
  - vec_req_ready = msix_enable.
  - On handshake with vec >= NUM_VECTORS: drop the request, pulse err_pulse, stay in IDLE.
  - Otherwise, if function_mask=1: set pba[vec] and stay in IDLE.
  - Otherwise latch vec and go to RD.
- Pending scan: runs in IDLE when vec_req_valid=0, msix_enable=1, function_mask=0 and pba is non-zero. It selects the first set bit at or after scan_ptr (wrapping), latches that vector, moves scan_ptr to the selected vector + 1 (wrapping), and goes to RD. New requests always take priority over the scan.
- RD: tbl_rd_req=1 with a stable tbl_rd_addr. On tbl_rd_ack, capture tbl_rd_data and go to EVAL.
- EVAL:
  - If function_mask, vector mask or !msix_enable: set pba[vec] and return to IDLE.
  - Otherwise register msg_addr/msg_data and go to SEND.
- SEND: msg_valid=1, with message fields stable until msg_ready. On handshake, clear pba[vec] and return to IDLE.
- A msg_valid that has been asserted is never retracted, even if the enable or a mask changes.
- A request for a vector that is already pending re-reads its entry; pba is cleared only by a successful send.
- pba keeps its contents while msix_enable=0; reset clears it.

## Timing
- Reset values: all outputs 0 except tbl_bir, which is combinational from its input; state IDLE; scan_ptr 0; pba all 0.
- Request handshake at cycle N → tbl_rd_req at N+1.
- Ack at cycle M → EVAL at M+1 → msg_valid at M+2.
- Minimum handshake-to-msg_valid latency is 3 cycles.
- msg_ready may be high before msg_valid. When both are high the handshake completes that cycle, and IDLE (with vec_req_ready) follows in the next cycle.
- vec_req_ready stays low in every state except IDLE.
- Reset mid-transaction drops the read and any message immediately; the read port must tolerate an abandoned request.

## Structure
- msix_pkg holds:
  - the state enum
  - ENTRY_BYTES=16
  - the entry field bit positions (ADDR_LO, ADDR_HI, DATA, MASK_BIT=96)
- Sub-module msix_pending_arbiter: combinational round-robin find-first-set over pba starting at scan_ptr. It returns found and idx.

## Test plan
- table_offset_bir=0x0000_2004, bar_base=0x1_0000_0000, vector 3, entry {lo=0xFEE0_0000, hi=0, data=0x4023, mask=0} → tbl_rd_addr=0x1_0000_2030; msg 0xFEE0_0000/0x4023 at ack+2; pba stays 0.
- Vector 5 with its entry mask=1 → no msg, pba[5]=1. Then drop vec_req_valid and return the same entry with mask=0 → scan re-reads vector 5, sends the msg and clears pba[5].
- function_mask=1 with requests for vectors 1 and 7 → no table reads, pba=0x82. Clear function_mask → vector 1 is sent, then vector 7 (round-robin order).
- vec_req_num=40 with NUM_VECTORS=32 → err_pulse for 1 cycle, no read, pba unchanged.
- Hold msg_ready low for 10 cycles while toggling msix_enable → msg_valid and its fields stay stable, and the send completes on ready.
- Assert rst_n low during RD → tbl_rd_req=0, state IDLE and pba=0 the next cycle.

Source files
------------

// File: rtl/msix_pkg.sv
// Shared definitions for the MSI-X message generator.
// Holds the FSM state encoding, the table entry geometry, the bit positions of
// the fields inside a 16-byte table entry, and the entry address helper.
package msix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_EVAL = 2'd2,
    ST_SEND = 2'd3
  } msix_state_e;

  localparam int ENTRY_BYTES = 16;

  // Field positions inside one table entry
  localparam int ADDR_LO  = 0;
  localparam int ADDR_HI  = 32;
  localparam int DATA     = 64;
  localparam int MASK_BIT = 96;

  // Table entry address: BAR base + QWORD-aligned table offset + vec * 16, wrapping at 2^64
  function automatic logic [63:0] msix_entry_addr(input logic [63:0] base,
                                                  input logic [31:0] offset_bir,
                                                  input logic [63:0] vec);
    return base + {32'h0000_0000, offset_bir[31:3], 3'b000} + (vec * 64'(ENTRY_BYTES));
  endfunction

endpackage

// File: rtl/msix_pending_arbiter.sv
// Round-robin find-first-set over the Pending Bit Array.
// Ports:
//   pba_i      pending bits
//   scan_ptr_i first position to consider (must be < NUM_VECTORS)
//   found_o    at least one bit is pending
//   idx_o      first pending vector at or after scan_ptr_i, wrapping
module msix_pending_arbiter
  import msix_pkg::*;
#(
  parameter int NUM_VECTORS = 32,
  parameter int VEC_W       = 11
) (
  input  logic [NUM_VECTORS-1:0] pba_i,
  input  logic [VEC_W-1:0]       scan_ptr_i,
  output logic                   found_o,
  output logic [VEC_W-1:0]       idx_o
);

  logic [NUM_VECTORS-1:0] rot_s;
  logic [VEC_W:0]         sum_s;

  // Rotate so that bit 0 of rot_s corresponds to scan_ptr_i
  assign rot_s = NUM_VECTORS'({pba_i, pba_i} >> scan_ptr_i);

  // Pick the lowest set bit of the rotated vector and map it back to a vector index
  always_comb begin
    found_o = 1'b0;
    idx_o   = {VEC_W{1'b0}};
    sum_s   = {(VEC_W + 1){1'b0}};
    for (int k = 0; k < NUM_VECTORS; k++) begin
      if (!found_o && rot_s[k]) begin
        found_o = 1'b1;
        sum_s   = {1'b0, scan_ptr_i} + (VEC_W + 1)'(k);
        if (sum_s >= (VEC_W + 1)'(NUM_VECTORS)) begin
          sum_s = sum_s - (VEC_W + 1)'(NUM_VECTORS);
        end else begin
          sum_s = sum_s;
        end
        idx_o = sum_s[VEC_W-1:0];
      end else begin
        found_o = found_o;
      end
    end
  end

endmodule

// File: rtl/msix_message_generator.sv
// MSI-X message generator.
// Turns per-vector interrupt requests into address/data memory-write messages.
// Each request reads its 16-byte table entry, checks function and vector masks,
// and either emits a message or records the vector in the PBA. Pending vectors
// are rescanned round-robin while idle and resent once unmasked.
// Ports:
//   table_offset_bir / tbl_bir / bar_base : table location (BIR out, BAR base in)
//   msix_enable, function_mask            : MSI-X control bits
//   vec_req_*                             : interrupt request handshake
//   tbl_rd_*                              : table entry read port (req held until ack)
//   msg_*                                 : message handshake to the TLP builder
//   pba                                   : pending bits
//   err_pulse                             : one-cycle flag for an out-of-range vector
module msix_message_generator
  import msix_pkg::*;
#(
  parameter int NUM_VECTORS = 32,
  parameter int VEC_W       = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            table_offset_bir,
  output logic [2:0]             tbl_bir,
  input  logic [63:0]            bar_base,
  input  logic                   msix_enable,
  input  logic                   function_mask,
  input  logic                   vec_req_valid,
  output logic                   vec_req_ready,
  input  logic [VEC_W-1:0]       vec_req_num,
  output logic                   tbl_rd_req,
  output logic [63:0]            tbl_rd_addr,
  input  logic                   tbl_rd_ack,
  input  logic [127:0]           tbl_rd_data,
  output logic                   msg_valid,
  input  logic                   msg_ready,
  output logic [63:0]            msg_addr,
  output logic [31:0]            msg_data,
  output logic [NUM_VECTORS-1:0] pba,
  output logic                   err_pulse
);

  msix_state_e            state_q, state_d;
  logic [VEC_W-1:0]       vec_q, vec_d;
  logic [VEC_W-1:0]       scan_ptr_q, scan_ptr_d;
  logic [63:0]            rd_addr_q, rd_addr_d;
  logic [31:0]            ent_lo_q, ent_lo_d;
  logic [31:0]            ent_hi_q, ent_hi_d;
  logic [31:0]            ent_data_q, ent_data_d;
  logic                   ent_mask_q, ent_mask_d;
  logic [63:0]            msg_addr_q, msg_addr_d;
  logic [31:0]            msg_data_q, msg_data_d;
  logic [NUM_VECTORS-1:0] pba_q, pba_d;
  logic                   err_q, err_d;

  logic                   scan_found_s;
  logic [VEC_W-1:0]       scan_idx_s;
  logic [VEC_W:0]         scan_next_s;
  logic                   req_oor_s;
  logic                   unused_s;

  // One-hot PBA bit for a vector index
  function automatic logic [NUM_VECTORS-1:0] vec_bit(input logic [VEC_W-1:0] v);
    logic [NUM_VECTORS-1:0] b;
    for (int i = 0; i < NUM_VECTORS; i++) begin
      b[i] = (v == VEC_W'(i));
    end
    return b;
  endfunction

  msix_pending_arbiter #(
    .NUM_VECTORS (NUM_VECTORS),
    .VEC_W       (VEC_W)
  ) u_arb (
    .pba_i      (pba_q),
    .scan_ptr_i (scan_ptr_q),
    .found_o    (scan_found_s),
    .idx_o      (scan_idx_s)
  );

  assign req_oor_s = 32'(vec_req_num) >= 32'(NUM_VECTORS);
  assign unused_s  = ^tbl_rd_data[127:MASK_BIT+1];

  // Scan pointer advance: one past the selected vector, wrapping
  always_comb begin
    scan_next_s = {1'b0, scan_idx_s} + {{VEC_W{1'b0}}, 1'b1};
    if (scan_next_s >= (VEC_W + 1)'(NUM_VECTORS)) begin
      scan_next_s = {(VEC_W + 1){1'b0}};
    end else begin
      scan_next_s = scan_next_s;
    end
  end

  // Request / scan / read / evaluate / send sequencing
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    scan_ptr_d = scan_ptr_q;
    rd_addr_d  = rd_addr_q;
    ent_lo_d   = ent_lo_q;
    ent_hi_d   = ent_hi_q;
    ent_data_d = ent_data_q;
    ent_mask_d = ent_mask_q;
    msg_addr_d = msg_addr_q;
    msg_data_d = msg_data_q;
    pba_d      = pba_q;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (vec_req_valid && msix_enable) begin
          if (req_oor_s) begin
            err_d = 1'b1;
          end else if (function_mask) begin
            pba_d = pba_q | vec_bit(vec_req_num);
          end else begin
            vec_d     = vec_req_num;
            rd_addr_d = msix_entry_addr(bar_base, table_offset_bir, 64'(vec_req_num));
            state_d   = ST_RD;
          end
        end else if (!vec_req_valid && msix_enable && !function_mask && scan_found_s) begin
          vec_d      = scan_idx_s;
          rd_addr_d  = msix_entry_addr(bar_base, table_offset_bir, 64'(scan_idx_s));
          scan_ptr_d = scan_next_s[VEC_W-1:0];
          state_d    = ST_RD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        if (tbl_rd_ack) begin
          ent_lo_d   = tbl_rd_data[ADDR_LO +: 32];
          ent_hi_d   = tbl_rd_data[ADDR_HI +: 32];
          ent_data_d = tbl_rd_data[DATA +: 32];
          ent_mask_d = tbl_rd_data[MASK_BIT];
          state_d    = ST_EVAL;
        end else begin
          state_d = ST_RD;
        end
      end
      ST_EVAL: begin
        if (function_mask || ent_mask_q || !msix_enable) begin
          pba_d   = pba_q | vec_bit(vec_q);
          state_d = ST_IDLE;
        end else begin
          msg_addr_d = {ent_hi_q, ent_lo_q[31:2], 2'b00};
          msg_data_d = ent_data_q;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        // Once raised, msg_valid is held regardless of enable/mask changes
        if (msg_ready) begin
          pba_d   = pba_q & ~vec_bit(vec_q);
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      vec_q      <= {VEC_W{1'b0}};
      scan_ptr_q <= {VEC_W{1'b0}};
      rd_addr_q  <= 64'h0;
      ent_lo_q   <= 32'h0;
      ent_hi_q   <= 32'h0;
      ent_data_q <= 32'h0;
      ent_mask_q <= 1'b0;
      msg_addr_q <= 64'h0;
      msg_data_q <= 32'h0;
      pba_q      <= {NUM_VECTORS{1'b0}};
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      scan_ptr_q <= scan_ptr_d;
      rd_addr_q  <= rd_addr_d;
      ent_lo_q   <= ent_lo_d;
      ent_hi_q   <= ent_hi_d;
      ent_data_q <= ent_data_d;
      ent_mask_q <= ent_mask_d;
      msg_addr_q <= msg_addr_d;
      msg_data_q <= msg_data_d;
      pba_q      <= pba_d;
      err_q      <= err_d;
    end
  end

  assign tbl_bir       = table_offset_bir[2:0];
  assign vec_req_ready = (state_q == ST_IDLE) && msix_enable;
  assign tbl_rd_req    = (state_q == ST_RD);
  assign tbl_rd_addr   = rd_addr_q;
  assign msg_valid     = (state_q == ST_SEND);
  assign msg_addr      = msg_addr_q;
  assign msg_data      = msg_data_q;
  assign pba           = pba_q;
  assign err_pulse     = err_q;

endmodule
